mem_arbiter: RTL and testbench

//   Arbitrates the single-ported RAM between the fetch-side (instruction) and memory-stage
//   (data) requesters of the pipelined MIPS core. Registers the grant, steers address, strobes
//   and store data to RAM, and returns load data plus wait handshakes to each side.

---
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data memory stage.
// Data side has priority, a streak counter bounds fetch starvation, a watchdog aborts hung accesses.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        mem_err
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam int unsigned WW = 8;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISERV = 2'd1,
    ST_DSERV = 2'd2
  } state_t;

  state_t          r_state;
  logic [SW-1:0]   r_streak;
  logic [WW-1:0]   r_wdog;

  logic w_dreq;
  logic w_iserv;
  logic w_dserv;
  logic w_serve;
  logic w_req;
  logic w_err;
  logic w_acc;
  logic w_tmo;
  logic w_done;
  logic w_exit;
  logic w_force_i;

  // Request/status decode for the side currently holding the grant
  assign w_dreq    = dREN | dWEN;
  assign w_iserv   = (r_state == ST_ISERV);
  assign w_dserv   = (r_state == ST_DSERV);
  assign w_serve   = w_iserv | w_dserv;
  assign w_req     = (w_iserv & iREN) | (w_dserv & w_dreq);
  assign w_err     = (ramstate == RAM_ERROR);
  assign w_acc     = (ramstate == RAM_ACCESS);
  assign w_tmo     = (r_wdog == WW'(TIMEOUT));
  assign w_done    = w_serve & w_req & ~w_err & ~w_tmo & w_acc;
  assign w_exit    = ~w_req | w_err | w_tmo | w_acc;
  assign w_force_i = iREN & (r_streak == SW'(STARVE_MAX));

  // An aborted access (error or timeout) never reports completion to its requester
  assign iwait   = iREN & ~(w_iserv & w_done);
  assign dwait   = w_dreq & ~(w_dserv & w_done);
  assign iload   = ramload;
  assign dload   = ramload;
  assign mem_err = w_serve & w_req & (w_err | w_tmo);

  // RAM steering follows the grant; strobes drop as soon as the state leaves a serve state
  assign ramREN   = w_iserv | (w_dserv & dREN & ~dWEN);
  assign ramWEN   = w_dserv & dWEN;
  assign ramaddr  = w_iserv ? iaddr : (w_dserv ? daddr : 32'd0);
  assign ramstore = w_dserv ? dstore : 32'd0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= ST_IDLE;
      r_streak <= '0;
      r_wdog   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_wdog <= '0;
          if (w_dreq && !w_force_i) begin
            r_state <= ST_DSERV;
          end else if (iREN) begin
            r_state <= ST_ISERV;
          end
        end
        ST_ISERV, ST_DSERV: begin
          if (w_exit) begin
            r_state <= ST_IDLE;
            r_wdog  <= '0;
          end else if (r_wdog != '1) begin
            r_wdog <= r_wdog + WW'(1);
          end
          // Streak only moves on a genuine completion
          if (w_done) begin
            if (w_dserv && iREN) begin
              if (r_streak != SW'(STARVE_MAX)) begin
                r_streak <= r_streak + SW'(1);
              end
            end else begin
              r_streak <= '0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_wdog  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus starvation, watchdog and reset sequences.
module tb_mem_arbiter;

  localparam logic L = 1'b0;
  localparam logic H = 1'b1;
  localparam logic [1:0] FREE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ACC  = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        mem_err;

  int n_cmp;
  int n_bad;

  mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(255)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL global time limit: sim still running at %0t, required finish earlier", $time);
    $fatal(1, "time limit");
  end

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] ds;
    logic [31:0] rl;
    logic [1:0]  rs;
    logic        e_iw;
    logic        e_dw;
    logic        e_rr;
    logic        e_rw;
    logic [31:0] e_ra;
    logic [31:0] e_rst;
    logic        e_me;
  } vec_t;

  localparam int NV = 23;
  vec_t vt [NV];

  function automatic vec_t mk(logic ir, logic [31:0] ia, logic dr, logic dw, logic [31:0] da,
                              logic [31:0] ds, logic [31:0] rl, logic [1:0] rs,
                              logic e_iw, logic e_dw, logic e_rr, logic e_rw,
                              logic [31:0] e_ra, logic [31:0] e_rst, logic e_me);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.ds = ds; v.rl = rl; v.rs = rs;
    v.e_iw = e_iw; v.e_dw = e_dw; v.e_rr = e_rr; v.e_rw = e_rw;
    v.e_ra = e_ra; v.e_rst = e_rst; v.e_me = e_me;
    return v;
  endfunction

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drop_all();
    iREN = L; dREN = L; dWEN = L;
    iaddr = 32'd0; daddr = 32'd0; dstore = 32'd0;
    ramstate = FREE;
  endtask

  task automatic chk_idle(input string nm, input logic e_iw, input logic e_dw);
    chk1({nm, " iwait"}, iwait, e_iw);
    chk1({nm, " dwait"}, dwait, e_dw);
    chk1({nm, " ramREN"}, ramREN, L);
    chk1({nm, " ramWEN"}, ramWEN, L);
    chk32({nm, " ramaddr"}, ramaddr, 32'd0);
    chk1({nm, " mem_err"}, mem_err, L);
  endtask

  // Caller is at a negedge with requests set; state must be IDLE with streak 0.
  // Expected: completions every second cycle, fetch wins on every fifth completion.
  task automatic starve_run(input string nm, input int ncyc);
    for (int c = 1; c <= ncyc; c++) begin
      if (c > 1) @(negedge CLK);
      ramstate = ACC;
      #1;
      if (c % 2 == 1) begin
        chk1($sformatf("%s c%0d iwait", nm, c), iwait, H);
        chk1($sformatf("%s c%0d dwait", nm, c), dwait, H);
      end else if (c % 10 == 0) begin
        chk1($sformatf("%s c%0d iwait", nm, c), iwait, L);
        chk1($sformatf("%s c%0d dwait", nm, c), dwait, H);
      end else begin
        chk1($sformatf("%s c%0d iwait", nm, c), iwait, H);
        chk1($sformatf("%s c%0d dwait", nm, c), dwait, L);
      end
      chk1($sformatf("%s c%0d mem_err", nm, c), mem_err, L);
    end
  endtask

  // Caller has checked the granting IDLE cycle; data request held with ramstate BUSY.
  task automatic wd_run(input string nm);
    for (int k = 0; k < 256; k++) begin
      @(negedge CLK);
      #1;
      chk1($sformatf("%s k%0d strobe", nm, k), ramREN | ramWEN, H);
      chk1($sformatf("%s k%0d mem_err", nm, k), mem_err, (k == 255));
      chk1($sformatf("%s k%0d dwait", nm, k), dwait, H);
    end
    @(negedge CLK);
    #1;
    chk_idle({nm, " post-abort"}, L, H);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    nRST = 1'b0;
    drop_all();
    ramload = 32'd0;

    //           ir ia            dr dw da           ds             rl            rs    iw dw rr rw ra            rst            me
    vt[0]  = mk(L, 32'h0,       L, L, 32'h0,     32'h0,         32'h11,       FREE, L, L, L, L, 32'h0,       32'h0,         L);
    vt[1]  = mk(H, 32'h40,      L, L, 32'h0,     32'h0,         32'h11,       FREE, H, L, L, L, 32'h0,       32'h0,         L);
    vt[2]  = mk(H, 32'h40,      L, L, 32'h0,     32'h0,         32'h1234,     ACC,  L, L, H, L, 32'h40,      32'h0,         L);
    vt[3]  = mk(L, 32'h0,       L, L, 32'h0,     32'h0,         32'h0,        FREE, L, L, L, L, 32'h0,       32'h0,         L);
    vt[4]  = mk(H, 32'h44,      L, H, 32'h100,   32'hDEADBEEF,  32'h0,        FREE, H, H, L, L, 32'h0,       32'h0,         L);
    vt[5]  = mk(H, 32'h44,      L, H, 32'h100,   32'hDEADBEEF,  32'h0,        BUSY, H, H, L, H, 32'h100,     32'hDEADBEEF,  L);
    vt[6]  = mk(H, 32'h44,      L, H, 32'h100,   32'hDEADBEEF,  32'h0,        ACC,  H, L, L, H, 32'h100,     32'hDEADBEEF,  L);
    vt[7]  = mk(H, 32'h44,      L, L, 32'h0,     32'h0,         32'h0,        FREE, H, L, L, L, 32'h0,       32'h0,         L);
    vt[8]  = mk(H, 32'h44,      L, L, 32'h0,     32'h0,         32'hCAFE,     ACC,  L, L, H, L, 32'h44,      32'h0,         L);
    vt[9]  = mk(L, 32'h0,       H, L, 32'h200,   32'h55,        32'h0,        FREE, L, H, L, L, 32'h0,       32'h0,         L);
    vt[10] = mk(L, 32'h0,       H, L, 32'h200,   32'h55,        32'hBEEF,     ACC,  L, L, H, L, 32'h200,     32'h55,        L);
    vt[11] = mk(L, 32'h0,       H, H, 32'h300,   32'h77,        32'h0,        FREE, L, H, L, L, 32'h0,       32'h0,         L);
    vt[12] = mk(L, 32'h0,       H, H, 32'h300,   32'h77,        32'h0,        BUSY, L, H, L, H, 32'h300,     32'h77,        L);
    vt[13] = mk(L, 32'h0,       L, L, 32'h300,   32'h77,        32'h0,        ACC,  L, L, L, L, 32'h300,     32'h77,        L);
    vt[14] = mk(L, 32'h0,       L, L, 32'h300,   32'h77,        32'h0,        FREE, L, L, L, L, 32'h0,       32'h0,         L);
    vt[15] = mk(H, 32'h80,      L, L, 32'h0,     32'h0,         32'h0,        FREE, H, L, L, L, 32'h0,       32'h0,         L);
    vt[16] = mk(H, 32'h80,      L, L, 32'h0,     32'h0,         32'h0,        ERR,  H, L, H, L, 32'h80,      32'h0,         H);
    vt[17] = mk(H, 32'h80,      L, L, 32'h0,     32'h0,         32'h0,        FREE, H, L, L, L, 32'h0,       32'h0,         L);
    vt[18] = mk(H, 32'h80,      L, L, 32'h0,     32'h0,         32'h99,       ACC,  L, L, H, L, 32'h80,      32'h0,         L);
    vt[19] = mk(L, 32'h0,       L, L, 32'h0,     32'h0,         32'h0,        FREE, L, L, L, L, 32'h0,       32'h0,         L);
    vt[20] = mk(H, 32'h90,      L, L, 32'h0,     32'h0,         32'h0,        FREE, H, L, L, L, 32'h0,       32'h0,         L);
    vt[21] = mk(L, 32'h90,      L, L, 32'h0,     32'h0,         32'h0,        ERR,  L, L, H, L, 32'h90,      32'h0,         L);
    vt[22] = mk(L, 32'h90,      L, L, 32'h0,     32'h0,         32'h0,        ERR,  L, L, L, L, 32'h0,       32'h0,         L);

    // Outputs while held in reset
    repeat (2) @(negedge CLK);
    iREN = H; dWEN = H; daddr = 32'h10; dstore = 32'h20; ramstate = ACC;
    #1;
    chk1("reset ramREN", ramREN, L);
    chk1("reset ramWEN", ramWEN, L);
    chk32("reset ramaddr", ramaddr, 32'd0);
    chk32("reset ramstore", ramstore, 32'd0);
    chk1("reset mem_err", mem_err, L);
    @(negedge CLK);
    drop_all();
    nRST = 1'b1;

    // Per-cycle vector table; state carries over between rows
    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      iREN = vt[i].ir; iaddr = vt[i].ia; dREN = vt[i].dr; dWEN = vt[i].dw;
      daddr = vt[i].da; dstore = vt[i].ds; ramload = vt[i].rl; ramstate = vt[i].rs;
      #1;
      chk1($sformatf("v%0d iwait", i), iwait, vt[i].e_iw);
      chk1($sformatf("v%0d dwait", i), dwait, vt[i].e_dw);
      chk1($sformatf("v%0d ramREN", i), ramREN, vt[i].e_rr);
      chk1($sformatf("v%0d ramWEN", i), ramWEN, vt[i].e_rw);
      chk32($sformatf("v%0d ramaddr", i), ramaddr, vt[i].e_ra);
      chk32($sformatf("v%0d ramstore", i), ramstore, vt[i].e_rst);
      chk1($sformatf("v%0d mem_err", i), mem_err, vt[i].e_me);
      chk32($sformatf("v%0d iload", i), iload, vt[i].rl);
      chk32($sformatf("v%0d dload", i), dload, vt[i].rl);
    end

    // Starvation: fetch held, data re-requesting every access
    @(negedge CLK);
    iREN = H; iaddr = 32'hA0; dREN = H; daddr = 32'hB0;
    starve_run("starve", 20);
    @(negedge CLK);
    drop_all();
    #1;
    chk_idle("after starve", L, L);

    // Watchdog abort on a data read stuck BUSY, then regrant and complete
    @(negedge CLK);
    dREN = H; daddr = 32'hC0; ramstate = BUSY;
    #1;
    chk_idle("wdog grant", L, H);
    wd_run("wdog");
    @(negedge CLK);
    ramstate = ACC;
    #1;
    chk1("wdog regrant ramREN", ramREN, H);
    chk32("wdog regrant ramaddr", ramaddr, 32'hC0);
    chk1("wdog regrant dwait", dwait, L);
    chk1("wdog regrant mem_err", mem_err, L);
    @(negedge CLK);
    drop_all();
    #1;
    chk_idle("after wdog", L, L);

    // Build streak to 2, then reset mid-write
    @(negedge CLK);
    iREN = H; iaddr = 32'hA0; dWEN = H; daddr = 32'hD0; dstore = 32'h5A; ramstate = ACC;
    #1;
    chk_idle("rst pre idle0", H, H);
    @(negedge CLK); #1;
    chk1("rst pre d1 dwait", dwait, L);
    @(negedge CLK); #1;
    chk_idle("rst pre idle1", H, H);
    @(negedge CLK); #1;
    chk1("rst pre d2 dwait", dwait, L);
    @(negedge CLK);
    ramstate = BUSY;
    #1;
    chk_idle("rst pre idle2", H, H);
    @(negedge CLK); #1;
    chk1("rst serve ramWEN", ramWEN, H);
    chk32("rst serve ramstore", ramstore, 32'h5A);
    @(negedge CLK); #1;
    chk1("rst serve2 ramWEN", ramWEN, H);
    #2;
    nRST = 1'b0;
    #1;
    chk1("rst async ramWEN", ramWEN, L);
    chk32("rst async ramaddr", ramaddr, 32'd0);
    chk32("rst async ramstore", ramstore, 32'd0);
    chk1("rst async mem_err", mem_err, L);
    chk1("rst async dwait", dwait, H);
    @(negedge CLK);
    nRST = 1'b1;
    starve_run("post-rst", 10);

    // Watchdog from fresh counter after reset
    @(negedge CLK);
    drop_all();
    #1;
    chk_idle("post-rst idle", L, L);
    @(negedge CLK);
    dWEN = H; daddr = 32'hE0; dstore = 32'h1; ramstate = BUSY;
    #1;
    chk_idle("wdog2 grant", L, H);
    wd_run("wdog2");
    @(negedge CLK);
    drop_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
